// File: rtl/ldpc_phase_scheduler.sv
// ldpc_phase_scheduler
//   Central sequencer for the PE_BLOCK / CNU array of the LDPC decoder.
//
//   Each iteration is one VNU phase followed by one CNU phase. A phase is a
//   sweep of L addresses (RUN) and then a pipeline-drain window (DRAIN). After
//   MAX_ITER iterations the scheduler passes through a one-cycle SWAP state.
//   SWAP either starts the next frame by flipping the bank select rs, or
//   returns to IDLE when no frame is waiting.
//
//   Handshake: start and frame_ready are levels sampled on the rising edge.
//   A transfer happens only when the scheduler is in IDLE with start=1 and
//   frame_ready=1, or in SWAP with frame_ready=1. The transfer is reported
//   by frame_ack, a one-cycle pulse in the first VNU_RUN cycle of the new
//   frame, which is also the cycle in which rs shows the new bank.
//
//   All outputs are registered. The block computes the next state, the
//   counters and the output values together, and loads them in one always_ff.
//   state_dbg gives checkers a view of the FSM state.
//
//   Optional feature, enabled by defining the macro LDPC_EARLY_TERM_EN:
//   adds the input syndrome_ok. It is sampled on the last CNU_DRAIN cycle,
//   and a high value ends the frame early by going to SWAP.
module ldpc_phase_scheduler #(
  parameter int L          = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int VNU_DELAY  = 4,
  parameter int CNU_DELAY  = 6,
  parameter int MAX_ITER   = 36,
  parameter int ITER_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  frame_ready,
`ifdef LDPC_EARLY_TERM_EN
  input  logic                  syndrome_ok,
`endif
  output logic                  frame_ack,
  output logic                  vnu_en,
  output logic                  cnu_en,
  output logic                  ag_en,
  output logic                  ag_reset,
  output logic                  addr_valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  rs,
  output logic [ITER_WIDTH-1:0] itr_count,
  output logic                  phase_done,
  output logic                  frame_done,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_VNU_RUN   = 3'd1,
    S_VNU_DRAIN = 3'd2,
    S_CNU_RUN   = 3'd3,
    S_CNU_DRAIN = 3'd4,
    S_SWAP      = 3'd5
  } state_t;

  // The drain counter must be wide enough for the longer of the two drain windows.
  localparam int MAX_DELAY = (VNU_DELAY > CNU_DELAY) ? VNU_DELAY : CNU_DELAY;
  localparam int DW        = $clog2(MAX_DELAY + 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(L - 1);
  localparam logic [DW-1:0]         VNU_LAST  = DW'(VNU_DELAY - 1);
  localparam logic [DW-1:0]         CNU_LAST  = DW'(CNU_DELAY - 1);
  localparam logic [ITER_WIDTH-1:0] ITER_LAST = ITER_WIDTH'(MAX_ITER - 1);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DW-1:0]         dcnt, dcnt_n;
  logic [ITER_WIDTH-1:0] itr_n;
  logic                  rs_n;
  logic                  ack_n;
  logic                  early_stop;
  logic                  run_n;
  logic                  phase_done_n;

`ifdef LDPC_EARLY_TERM_EN
  assign early_stop = syndrome_ok;
`else
  assign early_stop = 1'b0;
`endif

  assign state_dbg = state;

  // Next-state and counter logic: phase sequencing, address sweep, drain and iteration counting
  always_comb begin
    state_n = state;
    addr_n  = addr;
    dcnt_n  = dcnt;
    itr_n   = itr_count;
    rs_n    = rs;
    ack_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && frame_ready) begin
          state_n = S_VNU_RUN;
          addr_n  = '0;
          itr_n   = '0;
          rs_n    = ~rs;
          ack_n   = 1'b1;
        end
      end
      S_VNU_RUN: begin
        if (addr == ADDR_LAST) begin
          state_n = S_VNU_DRAIN;
          addr_n  = '0;
          dcnt_n  = '0;
        end else begin
          addr_n = addr + ADDR_WIDTH'(1);
        end
      end
      S_VNU_DRAIN: begin
        if (dcnt == VNU_LAST) begin
          state_n = S_CNU_RUN;
          addr_n  = '0;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      S_CNU_RUN: begin
        if (addr == ADDR_LAST) begin
          state_n = S_CNU_DRAIN;
          addr_n  = '0;
          dcnt_n  = '0;
        end else begin
          addr_n = addr + ADDR_WIDTH'(1);
        end
      end
      S_CNU_DRAIN: begin
        if (dcnt == CNU_LAST) begin
          // itr_count counts completed iterations, so during SWAP it shows the final total.
          itr_n = itr_count + ITER_WIDTH'(1);
          if ((itr_count == ITER_LAST) || early_stop) begin
            state_n = S_SWAP;
          end else begin
            state_n = S_VNU_RUN;
            addr_n  = '0;
          end
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      S_SWAP: begin
        itr_n = '0;
        if (frame_ready) begin
          state_n = S_VNU_RUN;
          addr_n  = '0;
          rs_n    = ~rs;
          ack_n   = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        addr_n  = '0;
        dcnt_n  = '0;
        itr_n   = '0;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with the state register
  always_comb begin
    run_n        = (state_n == S_VNU_RUN) || (state_n == S_CNU_RUN);
    phase_done_n = ((state_n == S_VNU_DRAIN) && (dcnt_n == VNU_LAST)) ||
                   ((state_n == S_CNU_DRAIN) && (dcnt_n == CNU_LAST));
  end

  // State, counter and output registers; reset returns the block to IDLE on bank 0
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      addr       <= '0;
      dcnt       <= '0;
      itr_count  <= '0;
      rs         <= 1'b0;
      frame_ack  <= 1'b0;
      vnu_en     <= 1'b0;
      cnu_en     <= 1'b0;
      ag_en      <= 1'b0;
      ag_reset   <= 1'b1;
      addr_valid <= 1'b0;
      phase_done <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      dcnt       <= dcnt_n;
      itr_count  <= itr_n;
      rs         <= rs_n;
      frame_ack  <= ack_n;
      vnu_en     <= (state_n == S_VNU_RUN) || (state_n == S_VNU_DRAIN);
      cnu_en     <= (state_n == S_CNU_RUN) || (state_n == S_CNU_DRAIN);
      ag_en      <= run_n;
      ag_reset   <= ~run_n;
      addr_valid <= run_n;
      phase_done <= phase_done_n;
      frame_done <= (state_n == S_SWAP);
      busy       <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_ldpc_phase_scheduler.sv
// Testbench for ldpc_phase_scheduler.
//   The reference model below treats a frame as a list of fixed-length
//   iterations. Each iteration is 2L+VNU_DELAY+CNU_DELAY cycles long. The
//   model derives each cycle's outputs from the position within the
//   iteration, and pushes one expected output word per clock into exp_q.
//   A monitor on the falling edge pops exp_q and compares it with the DUT.
module tb_ldpc_phase_scheduler;

  localparam int L    = 32;
  localparam int AW   = 5;
  localparam int VD   = 4;
  localparam int CD   = 6;
  localparam int MI   = 2;
  localparam int IW   = 6;
  localparam int P    = 2 * L + VD + CD;
  localparam int OW   = 6 + AW + 1 + IW + 3;

  logic          clk_df;
  logic          reset;
  logic          start;
  logic          frame_ready;
  logic          syndrome_ok;
  logic          frame_ack, vnu_en, cnu_en, ag_en, ag_reset, addr_valid;
  logic [AW-1:0] addr;
  logic          rs;
  logic [IW-1:0] itr_count;
  logic          phase_done, frame_done, busy;
  logic [2:0]    state_dbg;

  logic [OW-1:0] exp_q[$];
  int            checks;
  int            failures;

  // model state: mode 0 idle, 1 decoding, 2 swap
  int            m_mode;
  int            m_pos;
  int            m_iter;
  logic          m_rs;

  ldpc_phase_scheduler #(
    .L(L), .ADDR_WIDTH(AW), .VNU_DELAY(VD), .CNU_DELAY(CD),
    .MAX_ITER(MI), .ITER_WIDTH(IW)
  ) dut (
    .clk(clk_df),
    .reset(reset),
    .start(start),
    .frame_ready(frame_ready),
`ifdef LDPC_EARLY_TERM_EN
    .syndrome_ok(syndrome_ok),
`endif
    .frame_ack(frame_ack),
    .vnu_en(vnu_en),
    .cnu_en(cnu_en),
    .ag_en(ag_en),
    .ag_reset(ag_reset),
    .addr_valid(addr_valid),
    .addr(addr),
    .rs(rs),
    .itr_count(itr_count),
    .phase_done(phase_done),
    .frame_done(frame_done),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk_df = 1'b0;
  always #5 clk_df = ~clk_df;

  // reference model: advance one clock, then push the expected output word
  task automatic model_step();
    logic          ack, vnu, cnu, run, pd, fd, bsy, syn;
    logic [AW-1:0] a;
    logic [IW-1:0] it;
    int            p;
`ifdef LDPC_EARLY_TERM_EN
    syn = syndrome_ok;
`else
    syn = 1'b0;
`endif
    ack = 1'b0;
    if (!reset) begin
      m_mode = 0; m_pos = 0; m_iter = 0; m_rs = 1'b0;
    end else begin
      case (m_mode)
        0: if (start && frame_ready) begin
             m_mode = 1; m_pos = 0; m_iter = 0; m_rs = ~m_rs; ack = 1'b1;
           end
        1: if (m_pos == P - 1) begin
             m_iter = m_iter + 1;
             if (m_iter == MI || syn) m_mode = 2;
             else m_pos = 0;
           end else begin
             m_pos = m_pos + 1;
           end
        default: begin
          m_iter = 0;
          if (frame_ready) begin
            m_mode = 1; m_pos = 0; m_rs = ~m_rs; ack = 1'b1;
          end else begin
            m_mode = 0;
          end
        end
      endcase
    end
    vnu = 1'b0; cnu = 1'b0; run = 1'b0; pd = 1'b0; a = '0;
    fd  = (m_mode == 2);
    bsy = (m_mode != 0);
    it  = IW'(m_iter);
    if (m_mode == 1) begin
      p = m_pos;
      if (p < L) begin
        vnu = 1'b1; run = 1'b1; a = AW'(p);
      end else if (p < L + VD) begin
        vnu = 1'b1; pd = (p == L + VD - 1);
      end else if (p < 2 * L + VD) begin
        cnu = 1'b1; run = 1'b1; a = AW'(p - L - VD);
      end else begin
        cnu = 1'b1; pd = (p == P - 1);
      end
    end
    exp_q.push_back({ack, vnu, cnu, run, ~run, run, a, m_rs, it, pd, fd, bsy});
  endtask

  always @(posedge clk_df) model_step();

  // monitor: compare every presented output word against the scoreboard
  always @(negedge clk_df) begin
    logic [OW-1:0] e, act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {frame_ack, vnu_en, cnu_en, ag_en, ag_reset, addr_valid, addr, rs,
             itr_count, phase_done, frame_done, busy};
      checks = checks + 1;
      if (act !== e) begin
        failures = failures + 1;
        $display("FAIL outputs t=%0t got=%h expected=%h", $time, act, e);
      end
      checks = checks + 1;
      if (vnu_en && cnu_en) begin
        failures = failures + 1;
        $display("FAIL phase_overlap t=%0t vnu_en=%b cnu_en=%b required not both 1", $time, vnu_en, cnu_en);
      end
      checks = checks + 1;
      if (addr_valid && (int'(addr) >= L)) begin
        failures = failures + 1;
        $display("FAIL addr_range t=%0t addr=%0d required < %0d", $time, addr, L);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_df);
      #1;
    end
  endtask

  initial begin
    bit found;
    checks      = 0;
    failures    = 0;
    m_mode      = 0; m_pos = 0; m_iter = 0; m_rs = 1'b0;
    reset       = 1'b0;
    start       = 1'b0;
    frame_ready = 1'b0;
    syndrome_ok = 1'b0;
    tick(3);
    reset = 1'b1;

    // start without a frame: must stay idle
    start = 1'b1;
    tick(10);

    // first frame, then frame_ready held so SWAP chains into the next frame
    frame_ready = 1'b1;
    tick(1);
    start = 1'b0;
    tick(300);

    // no frame waiting at the next SWAP: back to IDLE
    frame_ready = 1'b0;
    tick(200);

    // reset during CNU_RUN at address 17
    start = 1'b1; frame_ready = 1'b1;
    tick(1);
    start = 1'b0; frame_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4 * P && !found; i++) begin
      if (m_mode == 1 && m_pos == L + VD + 17) found = 1'b1;
      else tick(1);
    end
    checks = checks + 1;
    if (!found) begin
      failures = failures + 1;
      $display("FAIL cnu_addr17_wait got=timeout required=reached");
    end
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(5);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) frame_ready = ~frame_ready;
      reset = ($urandom_range(0, 1999) != 0);
`ifdef LDPC_EARLY_TERM_EN
      syndrome_ok = ($urandom_range(0, 7) == 0);
`endif
      tick(1);
    end
    reset = 1'b1;
    tick(3);
    @(negedge clk_df);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
